// File: rtl/i2s_buf_pkg.sv
// Shared types and helpers for the I2S frame buffer: header marker,
// packer state encoding and a channel-enable popcount.
package i2s_buf_pkg;

    localparam logic [7:0] HDR_MARK = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        CH   = 2'd2
    } pk_state_t;

    // Counts set bits of a channel-enable mask (masks up to 32 channels).
    function automatic logic [6:0] popcount(input logic [31:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/i2s_frame_buffer_sync_fifo.sv
// Single-clock word FIFO with combinational read of the head word.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/i2s_frame_buffer.sv
// Captures one multichannel audio frame per word clock, packs header plus
// enabled samples into a word FIFO, and serializes words MSB-first as bytes.
module i2s_frame_buffer
    import i2s_buf_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 24,
    parameter int DEPTH    = 64
) (
    input  logic                         adc_clk,
    input  logic                         adc_rst_n,
    input  logic                         frame_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   frame_data,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         rd_req,
    input  logic                         clr_flags,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         busy,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int CW = SAMPLE_W - 8;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NB = SAMPLE_W / 8;
    localparam int BW = $clog2(NB);

    pk_state_t             state;
    pk_state_t             state_nxt;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_nxt;

    logic [NUM_CH*SAMPLE_W-1:0] frame_q;
    logic [NUM_CH-1:0]     en_q;
    logic [CW-1:0]         hdr_cnt_q;
    logic [CW-1:0]         frame_cnt;

    logic [6:0]            enabled;
    logic [31:0]           free_words;
    logic [31:0]           need_words;
    logic                  accept;
    logic                  drop;

    logic                  pk_push;
    logic [SAMPLE_W-1:0]   pk_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [SAMPLE_W-1:0]   head_word;

    logic [SAMPLE_W-1:0]   cur_word;
    logic [BW-1:0]         bi;
    logic [SAMPLE_W-1:0]   cur_shifted;
    logic                  pop;
    logic                  empty_read;

    // Admission: space is reserved for the whole frame at capture time.
    assign enabled    = popcount(32'(ch_enable));
    assign free_words = 32'(DEPTH) - 32'(fifo_level);
    assign need_words = 32'(enabled) + 32'd1;
    assign accept     = frame_valid && (ch_enable != '0) && (state == IDLE)
                        && (free_words >= need_words);
    assign drop       = frame_valid && (ch_enable != '0) && !accept;

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            frame_q   <= '0;
            en_q      <= '0;
            hdr_cnt_q <= '0;
            frame_cnt <= '0;
        end else begin
            if (frame_valid) frame_cnt <= frame_cnt + CW'(1);
            if (accept) begin
                frame_q   <= frame_data;
                en_q      <= ch_enable;
                hdr_cnt_q <= frame_cnt;
            end
        end
    end

    // Packer FSM: state register.
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Packer FSM: next state.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (accept) state_nxt = HDR;
            end
            HDR: begin
                state_nxt = CH;
                idx_nxt   = '0;
            end
            CH: begin
                if (32'(idx) == NUM_CH - 1) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Packer FSM: outputs.
    always_comb begin
        pk_push = 1'b0;
        pk_data = '0;
        busy    = (state != IDLE);
        case (state)
            HDR: begin
                pk_push = 1'b1;
                pk_data = {HDR_MARK, hdr_cnt_q};
            end
            CH: begin
                pk_push = en_q[idx];
                pk_data = frame_q[32'(idx)*SAMPLE_W +: SAMPLE_W];
            end
            default: begin
                pk_push = 1'b0;
                pk_data = '0;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (adc_clk),
        .rst_n     (adc_rst_n),
        .push      (pk_push && !fifo_full),
        .push_data (pk_data),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Serializer: byte 0 pops a fresh word, later bytes come from cur_word.
    assign pop         = rd_req && (bi == '0) && !fifo_empty;
    assign empty_read  = rd_req && (bi == '0) && fifo_empty;
    assign cur_shifted = cur_word << (32'(bi) * 8);

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            cur_word <= '0;
            bi       <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (bi == '0) begin
                    if (!fifo_empty) begin
                        cur_word <= head_word;
                        rd_data  <= head_word[SAMPLE_W-1 -: 8];
                        bi       <= BW'(1);
                    end else begin
                        rd_data <= 8'h00;
                    end
                end else begin
                    rd_data <= cur_shifted[SAMPLE_W-1 -: 8];
                    bi      <= (32'(bi) == NB - 1) ? '0 : bi + BW'(1);
                end
            end
        end
    end

    // Sticky flags; a set event in the same cycle beats clr_flags.
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (drop)           overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (empty_read)     underflow <= 1'b1;
            else if (clr_flags) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// Directed bench for i2s_frame_buffer: frame packing, byte readout, overflow,
// underflow, reset mid-word and concurrent pack/read with a byte scoreboard.
module tb_i2s_frame_buffer;
    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 24;
    localparam int DEPTH    = 16;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic                       adc_clk = 1'b0;
    logic                       adc_rst_n = 1'b0;
    logic                       frame_valid = 1'b0;
    logic [NUM_CH*SAMPLE_W-1:0] frame_data = '0;
    logic [NUM_CH-1:0]          ch_enable = '0;
    logic                       rd_req = 1'b0;
    logic                       clr_flags = 1'b0;
    logic [7:0]                 rd_data;
    logic                       rd_valid;
    logic [LW-1:0]              fifo_level;
    logic                       busy;
    logic                       overflow;
    logic                       underflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    i2s_frame_buffer #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH)
    ) dut (
        .adc_clk     (adc_clk),
        .adc_rst_n   (adc_rst_n),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .ch_enable   (ch_enable),
        .rd_req      (rd_req),
        .clr_flags   (clr_flags),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_level  (fifo_level),
        .busy        (busy),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Clock and reset
    always #5 adc_clk = ~adc_clk;

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic do_reset();
        adc_rst_n = 1'b0;
        tick();
        adc_rst_n = 1'b1;
    endtask

    // Checking
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drivers
    function automatic logic [SAMPLE_W-1:0] pattern(input int k);
        return {8'(8'hC0 + k), 8'(8'hD0 + k), 8'(8'hE0 + k)};
    endfunction

    function automatic logic [NUM_CH*SAMPLE_W-1:0] full_frame();
        logic [NUM_CH*SAMPLE_W-1:0] fd;
        fd = '0;
        for (int k = 0; k < NUM_CH; k++) fd[k*SAMPLE_W +: SAMPLE_W] = pattern(k);
        return fd;
    endfunction

    task automatic send_frame(input logic [NUM_CH-1:0] en, input logic [NUM_CH*SAMPLE_W-1:0] data);
        frame_valid = 1'b1;
        ch_enable   = en;
        frame_data  = data;
        tick();
        frame_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic read_word(input string tag, input logic [SAMPLE_W-1:0] w);
        read_byte({tag, "_b0"}, w[23:16]);
        read_byte({tag, "_b1"}, w[15:8]);
        read_byte({tag, "_b2"}, w[7:0]);
    endtask

    initial begin
        logic [NUM_CH*SAMPLE_W-1:0] fd;
        int max_lvl;

        // Reset values
        tick();
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        adc_rst_n = 1'b1;
        tick();

        // Single frame readout: A5 00 00 12 34 56 AB CD EF
        fd = '0;
        fd[0*SAMPLE_W +: SAMPLE_W] = 24'h123456;
        fd[1*SAMPLE_W +: SAMPLE_W] = 24'hABCDEF;
        send_frame(8'h03, fd);
        check("single_busy", 32'(busy), 32'd1);
        wait_idle("single_idle");
        check("single_level", 32'(fifo_level), 32'd3);
        read_word("single_hdr", 24'hA50000);
        read_word("single_ch0", 24'h123456);
        read_word("single_ch1", 24'hABCDEF);
        tick();
        check("single_valid_low", 32'(rd_valid), 32'd0);
        check("single_level_end", 32'(fifo_level), 32'd0);
        check("single_underflow", 32'(underflow), 32'd0);

        // Empty enable mask is discarded without overflow
        send_frame(8'h00, fd);
        check("zero_en_busy", 32'(busy), 32'd0);
        check("zero_en_overflow", 32'(overflow), 32'd0);
        check("zero_en_level", 32'(fifo_level), 32'd0);

        // Overflow on space check (DEPTH 16)
        do_reset();
        send_frame(8'hFF, full_frame());
        wait_idle("space_idle1");
        check("space_level1", 32'(fifo_level), 32'd9);
        send_frame(8'hFF, full_frame());
        check("space_overflow", 32'(overflow), 32'd1);
        check("space_busy", 32'(busy), 32'd0);
        check("space_level2", 32'(fifo_level), 32'd9);
        read_word("space_hdr0", 24'hA50000);
        for (int k = 0; k < NUM_CH; k++) read_word("space_ch", pattern(k));
        check("space_level_empty", 32'(fifo_level), 32'd0);
        fd = '0;
        fd[0 +: SAMPLE_W] = 24'h010203;
        send_frame(8'h01, fd);
        wait_idle("space_idle3");
        read_word("space_hdr2", 24'hA50002);
        read_word("space_ch0", 24'h010203);

        // Frame while busy: second frame at cycle 5 dropped
        do_reset();
        send_frame(8'hFF, full_frame());
        tick(); tick(); tick(); tick();
        send_frame(8'hFF, full_frame());
        check("busy_overflow", 32'(overflow), 32'd1);
        wait_idle("busy_idle");
        check("busy_level", 32'(fifo_level), 32'd9);
        read_word("busy_hdr0", 24'hA50000);
        for (int k = 0; k < NUM_CH; k++) read_word("busy_ch", pattern(k));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("busy_clr_overflow", 32'(overflow), 32'd0);
        send_frame(8'h80, full_frame());
        wait_idle("busy_idle2");
        read_word("busy_hdr2", 24'hA50002);
        read_word("busy_ch7", pattern(7));

        // Underflow and flag priority
        do_reset();
        read_byte("unf_data", 8'h00);
        check("unf_flag", 32'(underflow), 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("unf_cleared", 32'(underflow), 32'd0);
        clr_flags = 1'b1;
        rd_req    = 1'b1;
        tick();
        clr_flags = 1'b0;
        rd_req    = 1'b0;
        check("unf_set_wins", 32'(underflow), 32'd1);
        check("unf_set_wins_data", 32'(rd_data), 32'h00);

        // Reset mid-word with both flags set
        do_reset();
        read_byte("mid_empty", 8'h00);
        fd = '0;
        fd[0 +: SAMPLE_W] = 24'h778899;
        send_frame(8'h01, fd);
        send_frame(8'h01, fd);
        check("mid_overflow", 32'(overflow), 32'd1);
        wait_idle("mid_idle");
        check("mid_level", 32'(fifo_level), 32'd2);
        read_word("mid_hdr", 24'hA50000);
        read_byte("mid_first", 8'h77);
        do_reset();
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_underflow", 32'(underflow), 32'd0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_data", 32'(rd_data), 32'h00);
        fd[0 +: SAMPLE_W] = 24'h445566;
        send_frame(8'h01, fd);
        wait_idle("mid_idle2");
        read_word("mid_new_hdr", 24'hA50000);
        read_word("mid_new_ch0", 24'h445566);

        // Concurrent pack and read, scoreboard on byte stream
        do_reset();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        for (int k = 0; k < NUM_CH; k++) begin
            logic [SAMPLE_W-1:0] w;
            w = pattern(k);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        max_lvl = 0;
        send_frame(8'hFF, full_frame());
        tick();
        rd_req = 1'b1;
        for (int c = 0; c < 3 * (NUM_CH + 1); c++) begin
            tick();
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (rd_valid === 1'b1 && exp_q.size() > 0) begin
                check("conc_byte", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
        rd_req = 1'b0;
        tick();
        check("conc_remaining", 32'(exp_q.size()), 32'd0);
        check("conc_max_level_ok", 32'(max_lvl <= 9), 32'd1);
        check("conc_level_end", 32'(fifo_level), 32'd0);
        check("conc_underflow", 32'(underflow), 32'd0);
        check("conc_overflow", 32'(overflow), 32'd0);

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
